// File: rtl/gpu_network_interface.sv
// GPU-side endpoint of a leaf-router port: paced TX injection with local loopback,
// plus an RX FIFO with drop accounting. The router port has no backpressure.
module gpu_network_interface #(
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [3:0]  GROUP_ID   = 4'b1000,
  parameter int unsigned ROUTER_ID  = 4,
  parameter int unsigned TX_GAP     = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DWIDTH-1:0]             core_tx_data,
  input  logic [5:0]                    core_tx_dest,
  input  logic                          core_tx_valid,
  output logic                          core_tx_ready,
  output logic [DWIDTH-1:0]             core_rx_data,
  output logic                          core_rx_valid,
  input  logic                          core_rx_ready,
  output logic [DWIDTH-1:0]             net_out_data,
  output logic [5:0]                    net_out_dest,
  output logic                          net_out_valid,
  input  logic [DWIDTH-1:0]             net_in_data,
  input  logic                          net_in_valid,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic [7:0]                    drop_count,
  output logic                          rx_overflow,
  output logic [7:0]                    loopback_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned EW = DWIDTH + 6;
  localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
  localparam logic [5:0]    SELF     = {GROUP_ID, 2'(ROUTER_ID - 1)};
  localparam logic [3:0]    GAP_LOAD = (TX_GAP == 0) ? 4'd0 : 4'(TX_GAP - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t state, state_next;
  logic [3:0] gap_cnt, gap_next;

  // TX FIFO storage: entry is {dest, data}
  logic [EW-1:0]     tx_mem [FIFO_DEPTH];
  logic [AW-1:0]     tx_wr, tx_rd;
  logic [LW-1:0]     tx_cnt, tx_cnt_next;
  logic [EW-1:0]     tx_head;
  logic [5:0]        head_dest;
  logic [DWIDTH-1:0] head_data;
  logic              tx_push, tx_pop, tx_empty;

  logic [DWIDTH-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]     rx_wr, rx_rd, rx_rd_next;
  logic [LW-1:0]     rx_cnt, rx_cnt_next;
  logic [DWIDTH-1:0] rx_wdata, rx_head_next;
  logic              rx_full, rx_pop, rx_push, net_push, drop;
  logic              launch, loop_push, free;

  assign tx_head   = tx_mem[tx_rd];
  assign head_dest = tx_head[EW-1:DWIDTH];
  assign head_data = tx_head[DWIDTH-1:0];
  assign tx_empty  = (tx_cnt == '0);
  assign tx_push   = core_tx_valid && core_tx_ready;

  // TX FSM: a slot becomes free in IDLE or in the last cycle of the pacing interval,
  // so consecutive pulses are spaced by exactly TX_GAP idle cycles.
  always_comb begin
    state_next = state;
    gap_next   = gap_cnt;
    free       = 1'b0;
    launch     = 1'b0;
    loop_push  = 1'b0;
    tx_pop     = 1'b0;
    case (state)
      IDLE: free = 1'b1;
      SEND: begin
        if (TX_GAP == 0) begin
          free = 1'b1;
        end else begin
          state_next = GAP;
          gap_next   = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_cnt == 4'd0) free = 1'b1;
        else gap_next = gap_cnt - 4'd1;
      end
      default: state_next = IDLE;
    endcase
    if (free) begin
      state_next = IDLE;
      if (!tx_empty) begin
        if (head_dest != SELF) begin
          tx_pop     = 1'b1;
          launch     = 1'b1;
          state_next = SEND;
        end else if (!net_in_valid && !rx_full) begin
          // network traffic has priority over loopback for the RX write port
          tx_pop    = 1'b1;
          loop_push = 1'b1;
        end
      end
    end
  end

  assign tx_cnt_next = tx_cnt + LW'(tx_push) - LW'(tx_pop);

  // RX write arbitration and registered first-word-fall-through head
  assign rx_full      = (rx_cnt == DEPTH_L);
  assign rx_pop       = core_rx_valid && core_rx_ready;
  assign net_push     = net_in_valid && (!rx_full || rx_pop);
  assign drop         = net_in_valid && rx_full && !rx_pop;
  assign rx_push      = net_push || loop_push;
  assign rx_wdata     = net_in_valid ? net_in_data : head_data;
  assign rx_rd_next   = rx_rd + AW'(rx_pop);
  assign rx_cnt_next  = rx_cnt + LW'(rx_push) - LW'(rx_pop);

  always_comb begin
    rx_head_next = rx_mem[rx_rd_next];
    if (rx_cnt_next == '0)                   rx_head_next = '0;
    else if (rx_push && (rx_wr == rx_rd_next)) rx_head_next = rx_wdata;
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= {core_tx_dest, core_tx_data};
    if (rx_push) rx_mem[rx_wr] <= rx_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      gap_cnt        <= 4'd0;
      tx_wr          <= '0;
      tx_rd          <= '0;
      tx_cnt         <= '0;
      rx_wr          <= '0;
      rx_rd          <= '0;
      rx_cnt         <= '0;
      core_tx_ready  <= 1'b0;
      core_rx_valid  <= 1'b0;
      core_rx_data   <= '0;
      net_out_valid  <= 1'b0;
      net_out_data   <= '0;
      net_out_dest   <= '0;
      drop_count     <= 8'd0;
      rx_overflow    <= 1'b0;
      loopback_count <= 8'd0;
    end else begin
      state         <= state_next;
      gap_cnt       <= gap_next;
      if (tx_push) tx_wr <= tx_wr + AW'(1);
      if (tx_pop)  tx_rd <= tx_rd + AW'(1);
      tx_cnt        <= tx_cnt_next;
      core_tx_ready <= (tx_cnt_next != DEPTH_L);
      if (rx_push) rx_wr <= rx_wr + AW'(1);
      rx_rd         <= rx_rd_next;
      rx_cnt        <= rx_cnt_next;
      core_rx_valid <= (rx_cnt_next != '0);
      core_rx_data  <= rx_head_next;
      net_out_valid <= launch;
      if (launch) begin
        net_out_data <= head_data;
        net_out_dest <= head_dest;
      end
      if (drop) begin
        rx_overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
      if (loop_push) loopback_count <= loopback_count + 8'd1;
    end
  end

  assign tx_level = tx_cnt;
  assign rx_level = rx_cnt;

endmodule

// File: tb/tb_gpu_network_interface.sv
// Directed bench for gpu_network_interface: pacing, TX full, loopback, RX overflow, reset.
module tb_gpu_network_interface;

  localparam int unsigned DW = 16;
  localparam int unsigned LW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // default instance (TX_GAP=1)
  logic [DW-1:0] tx_data, rx_data, no_data, ni_data;
  logic [5:0]    tx_dest, no_dest;
  logic          tx_valid, tx_ready, rx_valid, rx_ready, no_valid, ni_valid, rx_ovf;
  logic [LW-1:0] tx_level, rx_level;
  logic [7:0]    drop_cnt, loop_cnt;

  // slow instance (TX_GAP=15) used to fill the TX FIFO
  logic [DW-1:0] s_tx_data, s_rx_data, s_no_data, s_ni_data;
  logic [5:0]    s_tx_dest, s_no_dest;
  logic          s_tx_valid, s_tx_ready, s_rx_valid, s_rx_ready, s_no_valid, s_ni_valid, s_ovf;
  logic [LW-1:0] s_tx_level, s_rx_level;
  logic [7:0]    s_drop, s_loop;

  gpu_network_interface u_dut (
    .clk(clk), .reset(reset),
    .core_tx_data(tx_data), .core_tx_dest(tx_dest), .core_tx_valid(tx_valid), .core_tx_ready(tx_ready),
    .core_rx_data(rx_data), .core_rx_valid(rx_valid), .core_rx_ready(rx_ready),
    .net_out_data(no_data), .net_out_dest(no_dest), .net_out_valid(no_valid),
    .net_in_data(ni_data), .net_in_valid(ni_valid),
    .tx_level(tx_level), .rx_level(rx_level), .drop_count(drop_cnt),
    .rx_overflow(rx_ovf), .loopback_count(loop_cnt)
  );

  gpu_network_interface #(.TX_GAP(15)) u_dut_slow (
    .clk(clk), .reset(reset),
    .core_tx_data(s_tx_data), .core_tx_dest(s_tx_dest), .core_tx_valid(s_tx_valid), .core_tx_ready(s_tx_ready),
    .core_rx_data(s_rx_data), .core_rx_valid(s_rx_valid), .core_rx_ready(s_rx_ready),
    .net_out_data(s_no_data), .net_out_dest(s_no_dest), .net_out_valid(s_no_valid),
    .net_in_data(s_ni_data), .net_in_valid(s_ni_valid),
    .tx_level(s_tx_level), .rx_level(s_rx_level), .drop_count(s_drop),
    .rx_overflow(s_ovf), .loopback_count(s_loop)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int m_pulses = 0;
  logic [DW-1:0] s_q[$];
  int            s_t[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (no_valid) m_pulses++;
    if (s_no_valid) begin
      s_q.push_back(s_no_data);
      s_t.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int p0;
    tx_data = '0; tx_dest = '0; tx_valid = 1'b0; rx_ready = 1'b0;
    ni_data = '0; ni_valid = 1'b0;
    s_tx_data = '0; s_tx_dest = '0; s_tx_valid = 1'b0; s_rx_ready = 1'b0;
    s_ni_data = '0; s_ni_valid = 1'b0;

    // reset state
    tick(); tick();
    check("rst_tx_ready", 32'(tx_ready), 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_no_valid", 32'(no_valid), 0);
    check("rst_no_data", 32'(no_data), 0);
    check("rst_no_dest", 32'(no_dest), 0);
    check("rst_levels", 32'({tx_level, rx_level}), 0);
    check("rst_counters", 32'({drop_cnt, loop_cnt, rx_ovf}), 0);
    check("rst_slow_outs", 32'({s_tx_ready, s_rx_valid, s_no_valid, s_ovf, s_tx_level, s_rx_level}), 0);
    check("rst_slow_data", 32'({s_rx_data, s_no_dest, s_drop, s_loop}), 0);
    reset = 1'b1;
    tick();
    check("ready_after_reset", 32'(tx_ready), 1);

    // pacing with TX_GAP=1: pulses two cycles apart
    tx_valid = 1'b1; tx_data = 16'h1111; tx_dest = 6'b010001;
    tick();
    check("t1_before_first", 32'(no_valid), 0);
    tx_data = 16'h2222; tx_dest = 6'b000000;
    tick();
    check("t1_p1_valid", 32'(no_valid), 1);
    check("t1_p1_data", 32'(no_data), 32'h1111);
    check("t1_p1_dest", 32'(no_dest), 32'b010001);
    tx_data = 16'h3333; tx_dest = 6'b000101;
    tick();
    check("t1_gap1", 32'(no_valid), 0);
    tx_valid = 1'b0;
    tick();
    check("t1_p2_valid", 32'(no_valid), 1);
    check("t1_p2_data", 32'(no_data), 32'h2222);
    check("t1_p2_dest", 32'(no_dest), 0);
    tick();
    check("t1_gap2", 32'(no_valid), 0);
    tick();
    check("t1_p3_valid", 32'(no_valid), 1);
    check("t1_p3_data", 32'(no_data), 32'h3333);
    check("t1_p3_dest", 32'(no_dest), 32'b000101);
    tick();
    check("t1_after", 32'(no_valid), 0);
    check("t1_hold_data", 32'(no_data), 32'h3333);
    check("t1_tx_empty", 32'(tx_level), 0);

    // TX full on the slow instance: 1 in flight + 8 buffered, 10th push ignored
    s_tx_valid = 1'b1; s_tx_dest = 6'b000001;
    for (int i = 0; i < 10; i++) begin
      s_tx_data = 16'(32'hA000 + i);
      tick();
      if (i == 8) begin
        check("t2_level_full", 32'(s_tx_level), 8);
        check("t2_ready_low", 32'(s_tx_ready), 0);
      end
    end
    check("t2_level_after_extra", 32'(s_tx_level), 8);
    s_tx_valid = 1'b0;
    for (int n = 0; n < 300 && s_q.size() < 9; n++) tick();
    check("t2_pulse_count", 32'(s_q.size()), 9);
    for (int i = 0; i < s_q.size() && i < 9; i++) begin
      check("t2_order", 32'(s_q[i]), 32'hA000 + 32'(i));
      if (i > 0) check("t2_spacing", 32'(s_t[i] - s_t[i-1]), 16);
    end
    tick();
    check("t2_drained", 32'(s_tx_level), 0);
    check("t2_ready_back", 32'(s_tx_ready), 1);

    // loopback to own address
    p0 = m_pulses;
    tx_valid = 1'b1; tx_data = 16'hABCD; tx_dest = 6'b100011;
    tick();
    tx_valid = 1'b0;
    tick();
    check("t3_rx_valid", 32'(rx_valid), 1);
    check("t3_rx_data", 32'(rx_data), 32'hABCD);
    check("t3_loop_cnt", 32'(loop_cnt), 1);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("t3_popped", 32'(rx_valid), 0);
    // loopback collides with a network word
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0; ni_valid = 1'b1; ni_data = 16'h5555;
    tick();
    ni_valid = 1'b0;
    check("t3_net_first_lvl", 32'(rx_level), 1);
    check("t3_net_first_data", 32'(rx_data), 32'h5555);
    check("t3_stalled_head", 32'(tx_level), 1);
    check("t3_loop_cnt_stall", 32'(loop_cnt), 1);
    tick();
    check("t3_loop_second_lvl", 32'(rx_level), 2);
    check("t3_loop_cnt2", 32'(loop_cnt), 2);
    rx_ready = 1'b1;
    tick();
    check("t3_second_word", 32'(rx_data), 32'hABCD);
    tick();
    rx_ready = 1'b0;
    check("t3_rx_empty", 32'(rx_level), 0);
    check("t3_no_inject", 32'(m_pulses - p0), 0);

    // RX overflow: 10 words into 8 entries
    ni_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      ni_data = 16'(i);
      tick();
    end
    ni_valid = 1'b0;
    check("t4_rx_level", 32'(rx_level), 8);
    check("t4_drop_cnt", 32'(drop_cnt), 2);
    check("t4_overflow", 32'(rx_ovf), 1);
    rx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("t4_pop_order", 32'(rx_data), 32'(i));
      tick();
    end
    rx_ready = 1'b0;
    check("t4_empty", 32'(rx_valid), 0);

    // RX full with simultaneous push and pop
    ni_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ni_data = 16'(32'h0011 + i);
      tick();
    end
    ni_data = 16'h0099; rx_ready = 1'b1;
    tick();
    ni_valid = 1'b0; rx_ready = 1'b0;
    check("t5_level", 32'(rx_level), 8);
    check("t5_no_drop", 32'(drop_cnt), 2);
    rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t5_order", 32'(rx_data), (i < 7) ? 32'h0012 + 32'(i) : 32'h0099);
      tick();
    end
    rx_ready = 1'b0;
    check("t5_empty", 32'(rx_level), 0);

    // reset during SEND with three words queued
    tx_valid = 1'b1; tx_dest = 6'b000010;
    for (int i = 0; i < 6; i++) begin
      tx_data = 16'(32'hC000 + i);
      tick();
    end
    check("t6_in_send", 32'(no_valid), 1);
    check("t6_send_data", 32'(no_data), 32'hC002);
    check("t6_queued", 32'(tx_level), 3);
    reset = 1'b0; tx_valid = 1'b0;
    tick();
    check("t6_rst_net", 32'({no_valid, no_dest, no_data}), 0);
    check("t6_rst_levels", 32'({tx_level, rx_level}), 0);
    check("t6_rst_core", 32'({tx_ready, rx_valid, rx_data}), 0);
    check("t6_rst_counters", 32'({drop_cnt, loop_cnt, rx_ovf}), 0);
    reset = 1'b1;
    p0 = m_pulses;
    tick();
    check("t6_ready_after", 32'(tx_ready), 1);
    for (int i = 0; i < 5; i++) tick();
    check("t6_no_stale_pulse", 32'(m_pulses - p0), 0);
    check("t6_tx_level", 32'(tx_level), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
